// File: rtl/hearts_hud_pkg.sv
// Shared game definitions for the hearts HUD: geometry defaults, sprite size and HUD FSM encoding.
package hearts_hud_pkg;
    localparam int HUD_X_DEF         = 16;
    localparam int HUD_Y_DEF         = 8;
    localparam int HEART_SPACING_DEF = 20;
    localparam int BLINK_FRAMES_DEF  = 48;

    localparam int HEART_COUNT  = 3;
    localparam int SPRITE_SIZE  = 8;
    localparam int SPRITE_SCALE = 2;
    localparam int HEART_PIX    = SPRITE_SIZE * SPRITE_SCALE;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BLINK     = 2'd1,
        ST_GAME_OVER = 2'd2
    } hud_state_t;
endpackage

// File: rtl/hearts_hud_sprite_rom.sv
// 8x8 one-bit heart bitmap; column 0 is the leftmost pixel (bit 7 of each row word).
module heart_sprite_rom (
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       bit_on
);
    logic [7:0] line_s;

    // Row lookup followed by column select
    always_comb begin
        line_s = 8'b0000_0000;
        case (row)
            3'd0:    line_s = 8'b0110_0110;
            3'd1:    line_s = 8'b1111_1111;
            3'd2:    line_s = 8'b1111_1111;
            3'd3:    line_s = 8'b1111_1111;
            3'd4:    line_s = 8'b0111_1110;
            3'd5:    line_s = 8'b0011_1100;
            3'd6:    line_s = 8'b0001_1000;
            default: line_s = 8'b0000_0000;
        endcase
        bit_on = line_s[3'd7 - col];
    end
endmodule

// File: rtl/hearts_hud.sv
// Life-heart overlay: draws up to three 2x-scaled heart sprites and blinks each heart as it is lost.
module hearts_hud
    import hearts_hud_pkg::*;
#(
    parameter int HUD_X         = HUD_X_DEF,
    parameter int HUD_Y         = HUD_Y_DEF,
    parameter int HEART_SPACING = HEART_SPACING_DEF,
    parameter int BLINK_FRAMES  = BLINK_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic [1:0] playerLives,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       video_active,
    output logic       heart_pixel,
    output logic       game_over
);
    if (HEART_SPACING < HEART_PIX) begin : g_bad_spacing
        $error("hearts_hud: HEART_SPACING must be at least the heart width");
    end

    localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);
    localparam logic [9:0] TOP_Y      = 10'(HUD_Y);
    localparam logic [9:0] HEART_W    = 10'(HEART_PIX);

    function automatic logic [9:0] heart_left(input int idx);
        return 10'(HUD_X + idx * HEART_SPACING);
    endfunction

    hud_state_t state_r, state_nx_s;
    logic       vsync_r;
    logic       frame_tick_s;
    logic [1:0] shown_r, shown_nx_s, shown_dec_s;
    logic [1:0] blink_idx_r, blink_idx_nx_s;
    logic [5:0] frame_cnt_r, frame_cnt_nx_s;

    assign frame_tick_s = vsync & ~vsync_r;
    assign shown_dec_s  = shown_r - 2'd1;

    // Next-state logic: lives are only sampled on the frame tick
    always_comb begin
        state_nx_s     = state_r;
        shown_nx_s     = shown_r;
        blink_idx_nx_s = blink_idx_r;
        frame_cnt_nx_s = frame_cnt_r;
        if (frame_tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (playerLives < shown_r) begin
                        state_nx_s     = ST_BLINK;
                        blink_idx_nx_s = shown_dec_s;
                        frame_cnt_nx_s = 6'd0;
                    end else if (playerLives > shown_r) begin
                        shown_nx_s = playerLives;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_BLINK: begin
                    if (frame_cnt_r == BLINK_LAST) begin
                        shown_nx_s     = shown_dec_s;
                        frame_cnt_nx_s = 6'd0;
                        if (shown_dec_s == 2'd0) begin
                            state_nx_s = ST_GAME_OVER;
                        end else if (shown_dec_s > playerLives) begin
                            // another life was lost in the same hit: blink the next heart down
                            state_nx_s     = ST_BLINK;
                            blink_idx_nx_s = shown_dec_s - 2'd1;
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
                    end else begin
                        frame_cnt_nx_s = frame_cnt_r + 6'd1;
                    end
                end
                ST_GAME_OVER: begin
                    if (playerLives != 2'd0) begin
                        shown_nx_s = playerLives;
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_GAME_OVER;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    logic [HEART_COUNT-1:0] in_x_s;
    logic [9:0]             dx_s [HEART_COUNT];
    logic [9:0]             dy_s;
    logic                   in_y_s;
    logic [2:0]             col_s;
    logic [1:0]             hit_idx_s;
    logic                   rom_bit_s;
    logic                   visible_s;

    for (genvar g = 0; g < HEART_COUNT; g++) begin : g_heart
        assign dx_s[g]   = pix_x - heart_left(g);
        assign in_x_s[g] = (pix_x >= heart_left(g)) && (dx_s[g] < HEART_W);
    end

    assign dy_s   = pix_y - TOP_Y;
    assign in_y_s = (pix_y >= TOP_Y) && (dy_s < HEART_W);

    // Regions never overlap, so OR-merging the per-heart column and index is a plain select
    always_comb begin
        col_s     = 3'd0;
        hit_idx_s = 2'd0;
        for (int i = 0; i < HEART_COUNT; i++) begin
            col_s     = col_s | (in_x_s[i] ? dx_s[i][3:1] : 3'd0);
            hit_idx_s = hit_idx_s | (in_x_s[i] ? 2'(i) : 2'd0);
        end
    end

    heart_sprite_rom u_rom (
        .row    (dy_s[3:1]),
        .col    (col_s),
        .bit_on (rom_bit_s)
    );

    assign visible_s = (hit_idx_s < shown_r) &&
                       !((state_r == ST_BLINK) && (hit_idx_s == blink_idx_r) && frame_cnt_r[3]);

    // State, counters and registered outputs; reset wins over a coincident tick
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            vsync_r     <= 1'b0;
            shown_r     <= 2'd3;
            blink_idx_r <= 2'd0;
            frame_cnt_r <= 6'd0;
            heart_pixel <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            vsync_r     <= vsync;
            shown_r     <= shown_nx_s;
            blink_idx_r <= blink_idx_nx_s;
            frame_cnt_r <= frame_cnt_nx_s;
            heart_pixel <= video_active & (|in_x_s) & in_y_s & rom_bit_s & visible_s;
            game_over   <= (state_nx_s == ST_GAME_OVER);
        end
    end
endmodule

// File: tb/tb_hearts_hud.sv
// Directed bench for hearts_hud: frame-level life/blink model plus per-cycle pixel and game_over compare.
module tb_hearts_hud;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic [1:0] playerLives = 2'd3;
    logic [9:0] pix_x = 10'd0;
    logic [9:0] pix_y = 10'd0;
    logic       video_active = 1'b0;
    logic       heart_pixel;
    logic       game_over;

    hearts_hud dut (
        .clk          (clk),
        .reset        (reset),
        .vsync        (vsync),
        .playerLives  (playerLives),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .video_active (video_active),
        .heart_pixel  (heart_pixel),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] shape [8];

    // Frame-level model: hearts shown, which heart is blinking (-1 none) and frames since it began
    int m_shown = 3;
    int m_blink = -1;
    int m_age   = 0;
    bit m_over  = 1'b0;

    bit exp_pending = 1'b0, chk_pending = 1'b0;
    bit exp_q = 1'b0, chk_q = 1'b0, go_q = 1'b0;

    function automatic bit heart_vis(int i);
        if (i >= m_shown) return 1'b0;
        if (i == m_blink && ((m_age / 8) % 2) == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_pix(int x, int y, bit va);
        if (!va) return 1'b0;
        if (y < 8 || y >= 24) return 1'b0;
        for (int i = 0; i < 3; i++) begin
            int left;
            left = 16 + 20 * i;
            if (x >= left && x < left + 16) return heart_vis(i) && shape[(y - 8) / 2][7 - (x - left) / 2];
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_shown = 3; m_blink = -1; m_age = 0; m_over = 1'b0;
    endtask

    task automatic model_tick(input int lives);
        if (m_over) begin
            if (lives > 0) begin m_shown = lives; m_over = 1'b0; end
        end else if (m_blink >= 0) begin
            m_age++;
            if (m_age == 48) begin
                m_shown--;
                m_blink = -1;
                if (m_shown == 0) m_over = 1'b1;
                else if (m_shown > lives) begin m_blink = m_shown - 1; m_age = 0; end
            end
        end else if (lives < m_shown) begin
            m_blink = m_shown - 1; m_age = 0;
        end else if (lives > m_shown) begin
            m_shown = lives;
        end
    endtask

    // Expectation pipeline matching the one-clock output register
    always @(posedge clk) begin
        exp_q <= exp_pending;
        chk_q <= chk_pending;
        go_q  <= m_over;
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_q) begin
            vectors++;
            if (heart_pixel !== exp_q) begin
                errors++;
                $display("FAIL pixel t=%0t: heart_pixel=%b expected %b", $time, heart_pixel, exp_q);
            end
            vectors++;
            if (game_over !== go_q) begin
                errors++;
                $display("FAIL game_over_track t=%0t: game_over=%b expected %b", $time, game_over, go_q);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int x, input int y, input bit va);
        pix_x = 10'(x); pix_y = 10'(y); video_active = va;
        exp_pending = exp_pix(x, y, va);
        chk_pending = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic probe(input int i, output int v);
        drive(16 + 20 * i + 6, 14, 1'b1);
        v = int'(heart_pixel);
    endtask

    task automatic vtick(input int lives);
        chk_pending = 1'b0;
        playerLives = 2'(lives);
        vsync = 1'b1;
        @(posedge clk); #1;
        model_tick(lives);
        @(posedge clk); #1;
        vsync = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int cycles);
        chk_pending = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < cycles; c++) begin @(posedge clk); #1; end
        model_reset();
        check("reset_heart_pixel", int'(heart_pixel), 0);
        check("reset_game_over", int'(game_over), 0);
        reset = 1'b0;
    endtask

    task automatic full_scan(input string name, input int exp_total);
        int total, minx, maxx, miny, maxy;
        total = 0; minx = 1023; maxx = 0; miny = 1023; maxy = 0;
        for (int y = 4; y < 28; y++) begin
            for (int x = 8; x < 84; x++) begin
                drive(x, y, 1'b1);
                if (heart_pixel) begin
                    total++;
                    if (x < minx) minx = x;
                    if (x > maxx) maxx = x;
                    if (y < miny) miny = y;
                    if (y > maxy) maxy = y;
                end
            end
        end
        check({name, "_count"}, total, exp_total);
        if (exp_total == 480) begin
            check({name, "_minx"}, minx, 16);
            check({name, "_maxx"}, maxx, 71);
            check({name, "_miny"}, miny, 8);
            check({name, "_maxy"}, maxy, 21);
        end
        check({name, "_game_over"}, int'(game_over), (exp_total == 0) ? 1 : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int v0, v1, v2;
        shape[0] = 8'b0110_0110; shape[1] = 8'b1111_1111;
        shape[2] = 8'b1111_1111; shape[3] = 8'b1111_1111;
        shape[4] = 8'b0111_1110; shape[5] = 8'b0011_1100;
        shape[6] = 8'b0001_1000; shape[7] = 8'b0000_0000;

        // Reset and three solid hearts
        @(posedge clk); #1;
        do_reset(2);
        full_scan("three_hearts", 480);

        // Gating and one-clock latency
        drive(22, 14, 1'b0);
        check("video_inactive", int'(heart_pixel), 0);
        drive(10, 14, 1'b1);
        check("outside_region", int'(heart_pixel), 0);
        pix_x = 10'd22; exp_pending = exp_pix(22, 14, 1'b1);
        #2;
        check("latency_before_edge", int'(heart_pixel), 0);
        @(posedge clk); #1;
        check("latency_after_edge", int'(heart_pixel), 1);

        // Single loss: heart 2 blinks 48 frames then disappears
        vtick(2);
        for (int f = 0; f < 50; f++) begin
            probe(0, v0); probe(1, v1); probe(2, v2);
            case (f)
                0, 7, 16, 32:              check("loss1_h2_on", v2, 1);
                8, 15, 31, 40, 47, 48, 49: check("loss1_h2_off", v2, 0);
                default: ;
            endcase
            if (f == 20) check("loss1_h1_solid", v1, 1);
            if (f < 49) vtick(2);
        end
        full_scan("two_hearts", 320);

        // Double loss in one tick: heart 2 then heart 1 blink
        do_reset(2);
        vtick(1);
        for (int f = 0; f < 98; f++) begin
            probe(0, v0); probe(1, v1); probe(2, v2);
            if (f == 8)  check("multi_h2_off", v2, 0);
            if (f == 47) check("multi_h1_solid", v1, 1);
            if (f == 48) begin check("multi_h2_gone", v2, 0); check("multi_h1_start", v1, 1); end
            if (f == 56) check("multi_h1_off", v1, 0);
            if (f == 96) begin check("multi_h1_gone", v1, 0); check("multi_h0_solid", v0, 1); end
            if (f < 97) vtick(1);
        end
        full_scan("one_heart", 160);

        // Last life lost, then revive
        vtick(0);
        for (int f = 0; f < 49; f++) begin
            probe(0, v0);
            if (f == 47) check("last_not_over_yet", int'(game_over), 0);
            if (f == 48) check("last_game_over", int'(game_over), 1);
            if (f < 48) vtick(0);
        end
        full_scan("no_hearts", 0);
        vtick(3);
        full_scan("revived", 480);

        // Reset in the middle of a blink
        vtick(2);
        for (int f = 0; f < 21; f++) begin
            probe(2, v2);
            if (f == 8) check("abort_h2_off", v2, 0);
            if (f < 20) vtick(2);
        end
        do_reset(1);
        full_scan("after_abort", 480);
        vtick(3);
        probe(2, v2);
        check("abort_idle_h2", v2, 1);

        // Heal during a blink is deferred until the blink completes
        vtick(2);
        for (int f = 0; f < 51; f++) begin
            probe(1, v1); probe(2, v2);
            if (f == 8)  check("heal_h2_off", v2, 0);
            if (f == 16) check("heal_h2_on", v2, 1);
            if (f == 48) check("heal_deferred", v2, 0);
            if (f == 49) check("heal_applied", v2, 1);
            if (f < 50) vtick(3);
        end

        chk_pending = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/hearts_hud.md
HEARTS_HUD -- requirements
Module: hearts_hud

Interface
REQ-001 The block SHALL have parameter HUD_X, default 16, meaning the left pixel column of heart 0.
REQ-002 The block SHALL have parameter HUD_Y, default 8, meaning the top pixel row of all hearts.
REQ-003 The block SHALL have parameter HEART_SPACING, default 20, meaning the horizontal pitch between heart origins in pixels.
REQ-004 The block SHALL have parameter BLINK_FRAMES, default 48, meaning the frame count for which a lost heart blinks.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port vsync, input, 1 bit: frame sync, level signal sampled in the clk domain.
REQ-008 The block SHALL have port playerLives, input, 2 bits: current life count from the lives counter, range 0..3.
REQ-009 The block SHALL have ports pix_x and pix_y, input, 10 bits each: current beam coordinates.
REQ-010 The block SHALL have port video_active, input, 1 bit: high in the visible area.
REQ-011 The block SHALL have port heart_pixel, output, 1 bit: draw a heart colour at this pixel.
REQ-012 The block SHALL have port game_over, output, 1 bit: all lives lost and the final blink has completed.

Function
REQ-013 Frame tick: vsync SHALL be registered, and a one-cycle frame_tick SHALL be asserted on a 0->1 transition only.
REQ-014 The FSM SHALL have states IDLE, BLINK and GAME_OVER, and it SHALL sample playerLives only on frame_tick.
REQ-015 shown_lives (2 bits) SHALL be the count of hearts drawn solid; hearts i=0..2 SHALL be drawn when i < shown_lives.
REQ-016 In IDLE on tick, playerLives < shown_lives SHALL cause BLINK with blink_idx = shown_lives-1 and frame_cnt = 0.
REQ-017 In IDLE on tick, playerLives > shown_lives (heal) SHALL load shown_lives = playerLives immediately, with the FSM remaining in IDLE.
REQ-018 In BLINK, frame_cnt (6 bits) SHALL increment on each tick, and heart blink_idx SHALL be hidden while frame_cnt[3] = 1 (8 frames on, 8 frames off).
REQ-019 In BLINK, the tick on which frame_cnt = BLINK_FRAMES-1 SHALL decrement shown_lives.
  - new shown_lives > playerLives: restart BLINK on the next heart (multi-hit); frame_cnt = 0.
  - new shown_lives = 0: go to GAME_OVER.
  - otherwise: go to IDLE.
REQ-020 In BLINK, a playerLives increase SHALL be ignored until the blink completes; an increase SHALL then be applied via the IDLE rule.
REQ-021 In GAME_OVER, game_over SHALL be 1; a tick with playerLives > 0 SHALL load shown_lives = playerLives and go to IDLE.
REQ-022 Heart i region SHALL be x in [HUD_X + i*HEART_SPACING, +16) and y in [HUD_Y, HUD_Y+16), using 10-bit unsigned compares.
REQ-023 Sprite addressing SHALL use an 8x8 one-bit bitmap scaled 2x: row = (pix_y-HUD_Y)>>1 and col = (pix_x-left)>>1, each 3 bits.
REQ-024 heart_pixel SHALL equal video_active AND in-region AND bitmap bit AND heart visible, and it SHALL be registered (1 clk latency from pix_x/pix_y).
REQ-025 Regions SHALL NOT overlap, since HEART_SPACING >= 16; HEART_SPACING < 16 SHALL be a parameter error.

Reset
REQ-026 Reset SHALL be synchronous and active-high, and SHALL take priority over frame_tick in the same cycle.
REQ-027 Reset SHALL set state = IDLE, shown_lives = 3, frame_cnt = 0, blink_idx = 0, heart_pixel = 0, game_over = 0, and the vsync register = 0.
REQ-028 Reset asserted mid-BLINK SHALL abort the blink, so that 3 solid hearts are drawn from the first pixel after release.

Structure
REQ-029 HUD geometry defaults, the FSM state encoding and the sprite size (8, scale 2) SHALL reside in the shared game package.
REQ-030 The 8x8 heart bitmap SHALL be a sub-module heart_sprite_rom: combinational, 3-bit row and 3-bit col in, 1-bit out.

Verification
REQ-031 The bench SHALL check: reset, 3 lives, frame scan -> exactly 3 heart shapes at x = 16, 36, 56, y = 8..23; game_over = 0.
REQ-032 The bench SHALL check: lives 3->2 before a vsync rise -> heart 2 hidden in frames 8-15, 24-31 and 40-47, absent from frame 48 onward; state returns to IDLE.
REQ-033 The bench SHALL check: lives 3->1 in a single tick -> heart 2 blinks 48 frames, then heart 1 blinks 48 frames; shown_lives ends at 1.
REQ-034 The bench SHALL check: lives 1->0 -> after 48 frames game_over = 1 and no hearts are drawn; then lives set to 3 -> on the next tick 3 hearts are drawn and game_over = 0.
REQ-035 The bench SHALL check: reset pulsed at frame 20 of a blink -> the next scan shows 3 solid hearts, state is IDLE, and game_over = 0.
REQ-036 The bench SHALL check: video_active = 0 inside a heart region -> heart_pixel = 0; heart_pixel lags a pix_x step by exactly 1 clk.
